// File: rtl/fpv_expander.sv
// fpv_expander: rebuilds a 13-bit two's-complement sample from an FPV word
// {S, E[2:0], F[4:0]} as (-1)^S * F * 2^E. The value is formed by shifting
// the significand left once per clock, E times, and then applying the sign.
// Valid/ready handshakes are used on both sides, and a free-running counter
// records how many results have been handed downstream.
module fpv_expander #(
    parameter bit ZERO_FAST = 1'b1,
    parameter int CNT_W     = 8
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic              S,
    input  logic [2:0]        E,
    input  logic [4:0]        F,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [12:0]       D,
    output logic [CNT_W-1:0]  conv_cnt,
    output logic              busy
);

    localparam logic [1:0] IDLE  = 2'd0;
    localparam logic [1:0] SHIFT = 2'd1;
    localparam logic [1:0] HOLD  = 2'd2;

    localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};

    logic [1:0]        r_state;
    logic              r_sign;
    logic [2:0]        r_cnt;
    logic [12:0]       r_acc;
    logic [12:0]       r_d;
    logic              r_outValid;
    logic [CNT_W-1:0]  r_convCnt;

    logic              w_accept;
    logic              w_zeroSkip;
    logic [12:0]       w_signed;

    // Words are taken only in IDLE, so the input handshake never depends on out_ready.
    assign in_ready   = (r_state == IDLE);
    assign busy       = (r_state != IDLE);
    assign w_accept   = in_valid && in_ready;
    assign w_zeroSkip = ZERO_FAST && (F == 5'd0);

    // Apply the sign once all shifts are done; -0 wraps back to 0 naturally.
    assign w_signed   = r_sign ? (~r_acc + 13'd1) : r_acc;

    assign out_valid  = r_outValid;
    assign D          = r_d;
    assign conv_cnt   = r_convCnt;

    // Control state: IDLE -> SHIFT (E+1 clocks) -> HOLD until the result is taken.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= IDLE;
        end else begin
            case (r_state)
                IDLE: begin
                    if (w_accept) begin
                        r_state <= w_zeroSkip ? HOLD : SHIFT;
                    end
                end
                SHIFT: begin
                    if (r_cnt == 3'd0) begin
                        r_state <= HOLD;
                    end
                end
                HOLD: begin
                    if (out_ready) begin
                        r_state <= IDLE;
                    end
                end
                default: r_state <= IDLE;
            endcase
        end
    end

    // Shift datapath: latch the word on accept, then double the accumulator once per clock.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_sign <= 1'b0;
            r_cnt  <= 3'd0;
            r_acc  <= 13'd0;
        end else if (r_state == IDLE) begin
            if (w_accept) begin
                r_sign <= S;
                r_cnt  <= E;
                r_acc  <= {8'b0, F};
            end
        end else if ((r_state == SHIFT) && (r_cnt != 3'd0)) begin
            r_acc <= r_acc << 1;
            r_cnt <= r_cnt - 3'd1;
        end
    end

    // Output register: loaded when shifting ends (or at once for a fast zero) and held through stalls.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_d        <= 13'd0;
            r_outValid <= 1'b0;
        end else begin
            case (r_state)
                IDLE: begin
                    if (w_accept && w_zeroSkip) begin
                        r_d        <= 13'd0;
                        r_outValid <= 1'b1;
                    end
                end
                SHIFT: begin
                    if (r_cnt == 3'd0) begin
                        r_d        <= w_signed;
                        r_outValid <= 1'b1;
                    end
                end
                HOLD: begin
                    if (out_ready) begin
                        r_outValid <= 1'b0;
                    end
                end
                default: r_outValid <= 1'b0;
            endcase
        end
    end

    // Completed-conversion counter, bumped on each output handshake and left to wrap.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_convCnt <= '0;
        end else if ((r_state == HOLD) && out_ready) begin
            r_convCnt <= r_convCnt + CNT_ONE;
        end
    end

endmodule

// File: tb/tb_fpv_expander.sv
// tb_fpv_expander: directed and random checks of the FPV expander. Expected
// results are computed from (-1)^S * F * 2^E when a word is sent, queued, and
// compared when the DUT presents its output.
module tb_fpv_expander;

    logic        clk;
    logic        rst;
    logic        inValid;
    logic        inReady;
    logic        sIn;
    logic [2:0]  eIn;
    logic [4:0]  fIn;
    logic        outValid;
    logic        outReady;
    logic [12:0] dOut;
    logic [7:0]  convCnt;
    logic        busy;

    logic        inValid0;
    logic        inReady0;
    logic        outValid0;
    logic [12:0] dOut0;
    logic [7:0]  convCnt0;
    logic        busy0;

    int          checks;
    int          failures;
    logic [7:0]  expCnt;
    logic [12:0] expQ[$];

    fpv_expander #(.ZERO_FAST(1'b1), .CNT_W(8)) dut (
        .clk(clk), .rst(rst),
        .in_valid(inValid), .in_ready(inReady),
        .S(sIn), .E(eIn), .F(fIn),
        .out_valid(outValid), .out_ready(outReady),
        .D(dOut), .conv_cnt(convCnt), .busy(busy)
    );

    // Second instance without the zero shortcut, always ready downstream.
    fpv_expander #(.ZERO_FAST(1'b0), .CNT_W(8)) dut0 (
        .clk(clk), .rst(rst),
        .in_valid(inValid0), .in_ready(inReady0),
        .S(sIn), .E(eIn), .F(fIn),
        .out_valid(outValid0), .out_ready(1'b1),
        .D(dOut0), .conv_cnt(convCnt0), .busy(busy0)
    );

    // Free-running 100 MHz style clock.
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Single comparison point: counts every check and reports any miss.
    task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("[TB] FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    // Present one word, wait (bounded) until it is accepted, and queue its expected result.
    task automatic applyStimulus(input logic s, input logic [2:0] e, input logic [4:0] f);
        int n;
        int v;
        logic [31:0] vv;
        sIn = s; eIn = e; fIn = f; inValid = 1'b1;
        n = 0;
        while (!inReady && n < 50) begin
            @(posedge clk); #1; n++;
        end
        checkOutput("acceptReady", 32'(inReady), 32'd1);
        @(posedge clk); #1;
        inValid = 1'b0;
        v = int'(f) << e;
        if (s) v = -v;
        vv = v;
        expQ.push_back(vv[12:0]);
    endtask

    // Wait (bounded) for the result, check latency and value, then take it.
    task automatic collectResult(input int expLat);
        int n;
        logic [12:0] expD;
        n = 0;
        while (!outValid && n < 20) begin
            @(posedge clk); #1; n++;
        end
        checkOutput("latency", 32'(n), 32'(expLat));
        expD = (expQ.size() > 0) ? expQ.pop_front() : 13'h1555;
        checkOutput("dataD", 32'(dOut), 32'(expD));
        outReady = 1'b1;
        @(posedge clk); #1;
        outReady = 1'b0;
        expCnt = expCnt + 8'd1;
        checkOutput("outValidDrop", 32'(outValid), 32'd0);
        checkOutput("convCnt", 32'(convCnt), 32'(expCnt));
        checkOutput("inReadyIdle", 32'(inReady), 32'd1);
        checkOutput("dKept", 32'(dOut), 32'(expD));
    endtask

    // Assert reset across a couple of edges and release it just after an edge.
    task automatic doReset();
        rst = 1'b1;
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
        expCnt = 8'd0;
        expQ.delete();
    endtask

    initial begin
        int n;
        logic s;
        logic [2:0] e;
        logic [4:0] f;
        checks = 0; failures = 0; expCnt = 8'd0;
        inValid = 1'b0; inValid0 = 1'b0; outReady = 1'b0;
        sIn = 1'b0; eIn = 3'd0; fIn = 5'd0;
        doReset();

        $display("[TB] reset values");
        checkOutput("rstInReady", 32'(inReady), 32'd1);
        checkOutput("rstOutValid", 32'(outValid), 32'd0);
        checkOutput("rstD", 32'(dOut), 32'd0);
        checkOutput("rstConvCnt", 32'(convCnt), 32'd0);
        checkOutput("rstBusy", 32'(busy), 32'd0);

        $display("[TB] basic and extreme words");
        applyStimulus(1'b0, 3'd1, 5'd29);
        checkOutput("busyShift", 32'(busy), 32'd1);
        checkOutput("inReadyShift", 32'(inReady), 32'd0);
        collectResult(2);
        checkOutput("d58", 32'(dOut), 32'h003A);
        applyStimulus(1'b0, 3'd7, 5'd31);
        collectResult(8);
        checkOutput("dMax", 32'(dOut), 32'h0F80);
        applyStimulus(1'b1, 3'd7, 5'd31);
        collectResult(8);
        checkOutput("dMin", 32'(dOut), 32'h1080);
        applyStimulus(1'b1, 3'd0, 5'd4);
        collectResult(1);
        checkOutput("dNeg4", 32'(dOut), 32'h1FFC);

        $display("[TB] negative zero, fast and slow");
        applyStimulus(1'b1, 3'd5, 5'd0);
        collectResult(0);
        sIn = 1'b1; eIn = 3'd5; fIn = 5'd0; inValid0 = 1'b1;
        @(posedge clk); #1;
        inValid0 = 1'b0;
        n = 0;
        while (!outValid0 && n < 20) begin
            @(posedge clk); #1; n++;
        end
        checkOutput("slowZeroLatency", 32'(n), 32'd6);
        checkOutput("slowZeroD", 32'(dOut0), 32'd0);
        @(posedge clk); #1;
        checkOutput("slowZeroCnt", 32'(convCnt0), 32'd1);

        $display("[TB] backpressure");
        applyStimulus(1'b0, 3'd3, 5'd16);
        n = 0;
        while (!outValid && n < 20) begin
            @(posedge clk); #1; n++;
        end
        checkOutput("bpLatency", 32'(n), 32'd4);
        for (int i = 0; i < 5; i++) begin
            inValid = i[0];
            sIn = ~i[0]; eIn = 3'(i); fIn = 5'(7 + i);
            @(posedge clk); #1;
            checkOutput("bpHoldD", 32'(dOut), 32'h0080);
            checkOutput("bpHoldValid", 32'(outValid), 32'd1);
            checkOutput("bpInReady", 32'(inReady), 32'd0);
            checkOutput("bpCnt", 32'(convCnt), 32'(expCnt));
        end
        inValid = 1'b0;
        collectResult(0);
        repeat (3) @(posedge clk);
        #1;
        checkOutput("bpNoExtraValid", 32'(outValid), 32'd0);
        checkOutput("bpNoExtraBusy", 32'(busy), 32'd0);
        checkOutput("bpCntOnce", 32'(convCnt), 32'(expCnt));

        $display("[TB] reset mid-shift");
        applyStimulus(1'b0, 3'd6, 5'd3);
        repeat (3) @(posedge clk);
        #2 rst = 1'b1;
        #1;
        checkOutput("midRstValid", 32'(outValid), 32'd0);
        checkOutput("midRstD", 32'(dOut), 32'd0);
        checkOutput("midRstCnt", 32'(convCnt), 32'd0);
        checkOutput("midRstBusy", 32'(busy), 32'd0);
        checkOutput("midRstReady", 32'(inReady), 32'd1);
        @(posedge clk); #2 rst = 1'b0;
        expCnt = 8'd0;
        expQ.delete();
        @(posedge clk); #1;
        checkOutput("postRstValid", 32'(outValid), 32'd0);
        applyStimulus(1'b0, 3'd2, 5'd5);
        collectResult(3);
        checkOutput("d20", 32'(dOut), 32'd20);

        $display("[TB] 256 random words with counter wrap");
        doReset();
        for (int i = 0; i < 256; i++) begin
            s = 1'($urandom_range(0, 1));
            e = 3'($urandom_range(0, 7));
            f = 5'($urandom_range(0, 31));
            applyStimulus(s, e, f);
            collectResult((f == 5'd0) ? 0 : int'(e) + 1);
        end
        checkOutput("wrapCnt", 32'(convCnt), 32'd0);

        $display("[TB] TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    // Absolute time limit so the run always ends.
    initial begin
        #2000000;
        $display("[TB] FAIL timeout observed=running expected=finished");
        $fatal(1, "[TB] timeout");
    end

endmodule
